// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter: accepts a word on a valid/ready handshake and
// shifts it out MSB-first, one sout_en strobe per bit, CLKS_PER_BIT clocks per bit.
module piso_tx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              load_valid,
    output logic              load_ready,
    output logic              sout,
    output logic              sout_en,
    output logic              busy,
    output logic              done
);

    localparam int BIT_W = $clog2(DATA_W);
    localparam int DIV_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [DATA_W-1:0] shreg, shreg_nxt;
    logic [BIT_W-1:0]  bit_cnt, bit_cnt_nxt;
    logic [DIV_W-1:0]  div_cnt, div_cnt_nxt;
    logic              bit_end;

    assign bit_end = (div_cnt == DIV_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            div_cnt <= '0;
        end else begin
            state   <= state_nxt;
            shreg   <= shreg_nxt;
            bit_cnt <= bit_cnt_nxt;
            div_cnt <= div_cnt_nxt;
        end
    end

    // Outputs decode only registered state, so load_valid/data_in never reach them combinationally.
    always_comb begin
        state_nxt   = state;
        shreg_nxt   = shreg;
        bit_cnt_nxt = bit_cnt;
        div_cnt_nxt = div_cnt;
        load_ready  = 1'b0;
        sout        = 1'b0;
        sout_en     = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;

        case (state)
            IDLE: begin
                load_ready = 1'b1;
                if (load_valid) begin
                    shreg_nxt   = data_in;
                    bit_cnt_nxt = '0;
                    div_cnt_nxt = '0;
                    state_nxt   = SHIFT;
                end
            end

            SHIFT: begin
                busy    = 1'b1;
                sout    = shreg[DATA_W-1];
                sout_en = bit_end;
                if (bit_end) begin
                    div_cnt_nxt = '0;
                    shreg_nxt   = {shreg[DATA_W-2:0], 1'b0};
                    if (bit_cnt == BIT_LAST) begin
                        bit_cnt_nxt = '0;
                        state_nxt   = DONE;
                    end else begin
                        bit_cnt_nxt = bit_cnt + BIT_W'(1);
                    end
                end else begin
                    div_cnt_nxt = div_cnt + DIV_W'(1);
                end
            end

            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_piso_tx.sv
// Directed bench for piso_tx at CLKS_PER_BIT=1 and 4, each feeding a downstream shift register model.
module tb_piso_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b0;

    logic [7:0] data1 = 8'h00;
    logic       lv1   = 1'b0;
    logic       lr1, so1, se1, bz1, dn1;

    logic [7:0] data4 = 8'h00;
    logic       lv4   = 1'b0;
    logic       lr4, so4, se4, bz4, dn4;

    logic [7:0] dout1, dout4;

    int errs   = 0;
    int checks = 0;

    always #5 clk = ~clk;

    piso_tx #(.DATA_W(8), .CLKS_PER_BIT(1)) u1 (
        .clk(clk), .rst(rst), .data_in(data1), .load_valid(lv1),
        .load_ready(lr1), .sout(so1), .sout_en(se1), .busy(bz1), .done(dn1)
    );

    piso_tx #(.DATA_W(8), .CLKS_PER_BIT(4)) u4 (
        .clk(clk), .rst(rst), .data_in(data4), .load_valid(lv4),
        .load_ready(lr4), .sout(so4), .sout_en(se4), .busy(bz4), .done(dn4)
    );

    // Downstream serial-to-parallel registers: din=sout, en=sout_en
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout1 <= 8'h00;
            dout4 <= 8'h00;
        end else begin
            if (se1) dout1 <= {dout1[6:0], so1};
            if (se4) dout4 <= {dout4[6:0], so4};
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst   = 1'b0;
        lv1   = 1'b1;
        data1 = 8'($urandom);
        lv4   = 1'b1;
        data4 = 8'($urandom);
        repeat (3) tick();
        checks++;
        if ({lr1, so1, se1, bz1, dn1} !== 5'b10000) begin
            errs++;
            $display("FAIL reset_u1 got=%b want=10000", {lr1, so1, se1, bz1, dn1});
        end
        checks++;
        if ({lr4, so4, se4, bz4, dn4} !== 5'b10000) begin
            errs++;
            $display("FAIL reset_u4 got=%b want=10000", {lr4, so4, se4, bz4, dn4});
        end
        rst   = 1'b1;
        lv4   = 1'b0;
        data1 = 8'hFF;
        tick();
        lv1 = 1'b0;
        checks++;
        if ({lr1, so1, se1, bz1, dn1} !== 5'b01110) begin
            errs++;
            $display("FAIL reset_preshift got=%b want=01110", {lr1, so1, se1, bz1, dn1});
        end
        tick();
        #3;
        rst = 1'b0;
        #1;
        checks++;
        if ({lr1, so1, se1, bz1, dn1} !== 5'b10000) begin
            errs++;
            $display("FAIL reset_async got=%b want=10000", {lr1, so1, se1, bz1, dn1});
        end
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_cpb1;
        logic [7:0] w = 8'hA5;
        data1 = w;
        lv1   = 1'b1;
        checks++;
        if (lr1 !== 1'b1) begin
            errs++;
            $display("FAIL cpb1_ready_idle got=%b want=1", lr1);
        end
        tick();
        lv1 = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            checks++;
            if ({so1, se1, bz1, dn1} !== {w[8-k], 3'b110}) begin
                errs++;
                $display("FAIL cpb1_bit%0d got=%b want=%b", k, {so1, se1, bz1, dn1}, {w[8-k], 3'b110});
            end
            tick();
        end
        checks++;
        if ({dn1, lr1, bz1} !== 3'b101) begin
            errs++;
            $display("FAIL cpb1_done got=%b want=101", {dn1, lr1, bz1});
        end
        tick();
        checks++;
        if ({dn1, lr1, bz1} !== 3'b010) begin
            errs++;
            $display("FAIL cpb1_idle got=%b want=010", {dn1, lr1, bz1});
        end
        checks++;
        if (dout1 !== 8'hA5) begin
            errs++;
            $display("FAIL cpb1_dout got=%h want=a5", dout1);
        end
    endtask

    task automatic test_cpb4;
        logic [7:0] w = 8'h3C;
        int strobes = 0;
        logic exp_en;
        data4 = w;
        lv4   = 1'b1;
        tick();
        lv4 = 1'b0;
        for (int c = 1; c <= 32; c++) begin
            exp_en = ((c % 4) == 0);
            checks++;
            if ({so4, se4, bz4, dn4} !== {w[7-(c-1)/4], exp_en, 2'b10}) begin
                errs++;
                $display("FAIL cpb4_cyc%0d got=%b want=%b", c, {so4, se4, bz4, dn4}, {w[7-(c-1)/4], exp_en, 2'b10});
            end
            if (se4) strobes++;
            tick();
        end
        checks++;
        if ({dn4, se4, lr4} !== 3'b100) begin
            errs++;
            $display("FAIL cpb4_done got=%b want=100", {dn4, se4, lr4});
        end
        checks++;
        if (strobes !== 8) begin
            errs++;
            $display("FAIL cpb4_strobes got=%0d want=8", strobes);
        end
        checks++;
        if (dout4 !== 8'h3C) begin
            errs++;
            $display("FAIL cpb4_dout got=%h want=3c", dout4);
        end
        tick();
        checks++;
        if ({lr4, bz4} !== 2'b10) begin
            errs++;
            $display("FAIL cpb4_idle got=%b want=10", {lr4, bz4});
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] w0 = 8'h01;
        data1 = w0;
        lv1   = 1'b1;
        tick();
        data1 = 8'hFF;
        for (int k = 1; k <= 8; k++) begin
            checks++;
            if ({so1, se1, lr1} !== {w0[8-k], 2'b10}) begin
                errs++;
                $display("FAIL b2b_w0_bit%0d got=%b want=%b", k, {so1, se1, lr1}, {w0[8-k], 2'b10});
            end
            tick();
        end
        checks++;
        if ({dn1, lr1, dout1} !== {2'b10, 8'h01}) begin
            errs++;
            $display("FAIL b2b_w0_done got=%b want=%b", {dn1, lr1, dout1}, {2'b10, 8'h01});
        end
        tick();
        checks++;
        if ({lr1, bz1} !== 2'b10) begin
            errs++;
            $display("FAIL b2b_gap got=%b want=10", {lr1, bz1});
        end
        tick();
        for (int k = 1; k <= 8; k++) begin
            checks++;
            if ({so1, se1, lr1, bz1} !== 4'b1101) begin
                errs++;
                $display("FAIL b2b_w1_bit%0d got=%b want=1101", k, {so1, se1, lr1, bz1});
            end
            tick();
        end
        checks++;
        if ({dn1, dout1} !== {1'b1, 8'hFF}) begin
            errs++;
            $display("FAIL b2b_w1_done got=%b want=%b", {dn1, dout1}, {1'b1, 8'hFF});
        end
        lv1 = 1'b0;
        tick();
        checks++;
        if ({lr1, bz1, dn1} !== 3'b100) begin
            errs++;
            $display("FAIL b2b_idle got=%b want=100", {lr1, bz1, dn1});
        end
        tick();
        checks++;
        if ({bz1, se1} !== 2'b00) begin
            errs++;
            $display("FAIL b2b_no_extra got=%b want=00", {bz1, se1});
        end
    endtask

    task automatic test_reset_mid;
        data1 = 8'h96;
        lv1   = 1'b1;
        tick();
        lv1 = 1'b0;
        repeat (3) tick();
        checks++;
        if (dout1 !== 8'hFC) begin
            errs++;
            $display("FAIL rmid_partial got=%h want=fc", dout1);
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({lr1, so1, se1, bz1, dn1} !== 5'b10000) begin
            errs++;
            $display("FAIL rmid_abort got=%b want=10000", {lr1, so1, se1, bz1, dn1});
        end
        tick();
        checks++;
        if ({dn1, bz1} !== 2'b00) begin
            errs++;
            $display("FAIL rmid_no_done got=%b want=00", {dn1, bz1});
        end
        rst   = 1'b1;
        data1 = 8'h5A;
        lv1   = 1'b1;
        tick();
        lv1 = 1'b0;
        repeat (8) tick();
        checks++;
        if ({dn1, dout1} !== {1'b1, 8'h5A}) begin
            errs++;
            $display("FAIL rmid_reload got=%b want=%b", {dn1, dout1}, {1'b1, 8'h5A});
        end
        tick();
    endtask

    task automatic test_boundary;
        logic [7:0] bw [2] = '{8'h00, 8'hFF};
        logic [7:0] w;
        int strobes;
        for (int i = 0; i < 2; i++) begin
            w       = bw[i];
            strobes = 0;
            data1   = w;
            lv1     = 1'b1;
            tick();
            lv1 = 1'b0;
            for (int k = 1; k <= 8; k++) begin
                checks++;
                if (so1 !== w[7]) begin
                    errs++;
                    $display("FAIL bound_%h_bit%0d got=%b want=%b", w, k, so1, w[7]);
                end
                if (se1) strobes++;
                tick();
            end
            checks++;
            if ({strobes == 8, se1, dn1} !== 3'b101) begin
                errs++;
                $display("FAIL bound_%h_strobes got=%0d se=%b done=%b want=8,0,1", w, strobes, se1, dn1);
            end
            checks++;
            if (dout1 !== w) begin
                errs++;
                $display("FAIL bound_%h_dout got=%h want=%h", w, dout1, w);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_cpb1();
        test_cpb4();
        test_back_to_back();
        test_reset_mid();
        test_boundary();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
